instr_mem_loader: RTL and testbench

//  Byte-serial program loader directly upstream of the instruction-fetch stage.

---
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-serial program loader: length-prefixed little-endian image -> 32-bit instruction memory writes.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int DATA_WIDTH        = 32,
    parameter int INSTR_MEM_DEPTH   = 256,
    localparam int ADDR_WIDTH       = $clog2(INSTR_MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_restart,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_reset_n,
    output logic                  o_load_done,
    output logic                  o_load_err
);

    localparam int MAX_WORDS = INSTR_MEM_DEPTH / 4;
    localparam int WIDX_W    = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word (or an empty image) has been written.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CSUM;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t              state, state_next;
    logic [15:0]         n_words;
    logic [1:0]          byte_cnt;
    logic [WIDX_W-1:0]   word_idx;
    logic [DATA_WIDTH-1:0] word_buf;
    logic                rx_ready;
    logic                accept;
    logic [15:0]         len_full;
    logic                last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign accept    = i_rx_valid && rx_ready;
    assign len_full  = {i_rx_data, n_words[7:0]};
    assign last_word = (16'(word_idx) == (n_words - 16'd1));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        unique case (state)
            S_LEN0, S_LEN1, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                 rx_ready = 1'b1;
`endif
            default:                rx_ready = 1'b0;
        endcase

        if (i_restart) begin
            state_next = S_LEN0;
        end else begin
            unique case (state)
                S_LEN0: if (accept) state_next = S_LEN1;
                S_LEN1: begin
                    if (accept) begin
                        if (len_full == 16'd0)                  state_next = S_FINAL;
                        else if (len_full > 16'(MAX_WORDS))     state_next = S_ERR;
                        else                                    state_next = S_DATA;
                    end
                end
                S_DATA:  if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
                S_WRITE: state_next = last_word ? S_FINAL : S_DATA;
`ifdef LOADER_CHECKSUM_EN
                S_CSUM:  if (accept) state_next = (i_rx_data == csum) ? S_DONE : S_ERR;
`endif
                default: state_next = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_LEN0;
        else         state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            n_words  <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (i_restart) begin
            // Restart takes priority over a byte handshake in the same cycle.
            n_words  <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (accept) begin
                unique case (state)
                    S_LEN0: n_words[7:0]  <= i_rx_data;
                    S_LEN1: n_words[15:8] <= i_rx_data;
                    S_DATA: begin
                        word_buf[8*byte_cnt +: 8] <= i_rx_data;
                        byte_cnt                  <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if (state != S_CSUM) csum <= csum ^ i_rx_data;
`endif
            end
            if (state == S_WRITE) word_idx <= word_idx + 1'b1;
        end
    end

    assign o_rx_ready    = rx_ready;
    assign o_imem_we     = (state == S_WRITE);
    assign o_imem_addr   = {word_idx, 2'b00};
    assign o_imem_wdata  = word_buf;
    assign o_cpu_reset_n = (state == S_DONE);
    assign o_load_done   = (state == S_DONE);
    assign o_load_err    = (state == S_ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: write scoreboard plus state/flag checks.
// Follows LOADER_CHECKSUM_EN so the same sequence covers both builds.
module tb_instr_mem_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_restart;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_reset_n;
    logic        o_load_done;
    logic        o_load_err;

    wr_t         sb[$];
    logic [31:0] img_words[$];
    logic [7:0]  run_xor;
    int          n_cmp = 0;
    int          n_err = 0;
    int          gap_max = 0;

    instr_mem_loader dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_restart     (i_restart),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_rx_ready    (o_rx_ready),
        .o_imem_we     (o_imem_we),
        .o_imem_addr   (o_imem_addr),
        .o_imem_wdata  (o_imem_wdata),
        .o_cpu_reset_n (o_cpu_reset_n),
        .o_load_done   (o_load_done),
        .o_load_err    (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest pushed expectation.
    always @(negedge i_clk) begin
        if (o_imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(o_imem_we), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_addr", 32'(o_imem_addr), 32'(e.addr));
                check("write_data", o_imem_wdata, e.data);
            end
        end
    end

    task automatic idle(input int n);
        i_rx_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        idle($urandom_range(0, gap_max));
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        run_xor    = run_xor ^ b;
        forever begin
            @(negedge i_clk);
            if (o_rx_ready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                check("ready_timeout", 32'(o_rx_ready), 32'd1);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic pulse_restart(input logic with_valid);
        i_rx_valid = with_valid;
        i_rx_data  = 8'h05;
        i_restart  = 1'b1;
        @(posedge i_clk);
        #1;
        i_restart  = 1'b0;
        i_rx_valid = 1'b0;
        run_xor    = 8'h00;
    endtask

    // Sends LEN, all words of img_words and (checksum build) the XOR byte.
    task automatic load_image();
        int n;
        n = img_words.size();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = 8'(4 * w);
            e.data = img_words[w];
            sb.push_back(e);
            for (int k = 0; k < 4; k++) send_byte(img_words[w][8*k +: 8]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic wait_final();
        int t;
        t = 0;
        forever begin
            @(negedge i_clk);
            if (o_load_done === 1'b1 || o_load_err === 1'b1) break;
            t++;
            if (t > 100) begin
                check("final_timeout", 32'(o_load_done | o_load_err), 32'd1);
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(o_rx_ready), 32'd1);
        check({tag, "_we"},    32'(o_imem_we), 32'd0);
        check({tag, "_addr"},  32'(o_imem_addr), 32'd0);
        check({tag, "_wdata"}, o_imem_wdata, 32'd0);
        check({tag, "_cpurn"}, 32'(o_cpu_reset_n), 32'd0);
        check({tag, "_done"},  32'(o_load_done), 32'd0);
        check({tag, "_err"},   32'(o_load_err), 32'd0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},  32'(o_load_done), 32'd1);
        check({tag, "_cpurn"}, 32'(o_cpu_reset_n), 32'd1);
        check({tag, "_err"},   32'(o_load_err), 32'd0);
        check({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
        check({tag, "_sb"},    32'(sb.size()), 32'd0);
    endtask

    task automatic check_err(input string tag);
        check({tag, "_err"},   32'(o_load_err), 32'd1);
        check({tag, "_cpurn"}, 32'(o_cpu_reset_n), 32'd0);
        check({tag, "_done"},  32'(o_load_done), 32'd0);
        check({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
        check({tag, "_sb"},    32'(sb.size()), 32'd0);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_restart  = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        run_xor    = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_vals("reset");
        i_reset = 1'b0;
        idle(2);

        // Reference two-word image.
        img_words = '{32'h0010_0013, 32'h0000_0063};
        load_image();
        wait_final();
        check_done("two_words");

        // Valid bytes while done must be ignored.
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hA5;
        repeat (5) @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        check_done("ignore_in_done");

        pulse_restart(1'b0);
        check_reset_vals("after_restart");

        // Length over capacity: 65 words.
        send_byte(8'h41);
        send_byte(8'h00);
        wait_final();
        check_err("len_too_big");
        pulse_restart(1'b0);

        // Empty image.
        img_words = {};
        load_image();
        wait_final();
        check_done("len_zero");
        pulse_restart(1'b0);

        // Full memory with gaps: last address 0xFC.
        gap_max = 2;
        img_words = {};
        for (int i = 0; i < 64; i++) img_words.push_back($urandom);
        load_image();
        wait_final();
        check_done("full_mem");
        pulse_restart(1'b0);

        // Restart after two bytes of word 1, with a byte offered in the restart cycle.
        send_byte(8'h03);
        send_byte(8'h00);
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = 32'hCAFE_0001;
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) send_byte(8'(32'hCAFE_0001 >> (8 * k)));
        send_byte(8'h11);
        send_byte(8'h22);
        idle(3);
        pulse_restart(1'b1);
        check("restart_mid_sb", 32'(sb.size()), 32'd0);
        check("restart_mid_ready", 32'(o_rx_ready), 32'd1);
        check("restart_mid_cpurn", 32'(o_cpu_reset_n), 32'd0);
        img_words = '{32'h1234_5678, 32'h9ABC_DEF0};
        load_image();
        wait_final();
        check_done("reload");
        pulse_restart(1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch then match on the reference one-word image.
        begin
            wr_t e;
            e.addr = 8'h00;
            e.data = 32'h0010_0013;
            sb.push_back(e);
            foreach (img_words[i]) ;
            send_byte(8'h01); send_byte(8'h00);
            for (int k = 0; k < 4; k++) send_byte(8'(32'h0010_0013 >> (8 * k)));
            send_byte(8'h03);
            wait_final();
            check_err("csum_bad");
            pulse_restart(1'b0);
            sb.push_back(e);
            send_byte(8'h01); send_byte(8'h00);
            for (int k = 0; k < 4; k++) send_byte(8'(32'h0010_0013 >> (8 * k)));
            send_byte(8'h02);
            wait_final();
            check_done("csum_good");
            pulse_restart(1'b0);
        end
`endif

        // Asynchronous reset in the middle of a word.
        gap_max = 0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h7E);
        send_byte(8'h5D);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        run_xor = 8'h00;
        idle(1);
        img_words = '{32'h0BAD_F00D};
        load_image();
        wait_final();
        check_done("after_async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
